// File: rtl/exu_stage.sv
// rtl/exu_stage.sv - RV64 execute stage: forwarding, ALU, branch resolve, flush, EX/MEM register.
// Optional multiply/divide (opcodes 10-17) is built only when EXU_MULDIV_EN is defined.
module exu_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  idu_index_rs1,
  input  logic [4:0]  idu_index_rs2,
  input  logic [4:0]  idu_index_rd,
  input  logic [63:0] idu_pc,
  input  logic [63:0] idu_snxt_pc,
  input  logic [63:0] idu_imm,
  input  logic [63:0] idu_gpr_data1,
  input  logic [63:0] idu_gpr_data2,
  input  logic        idu_alu_en,
  input  logic        idu_alu_imm_en,
  input  logic        idu_alu_pc_en,
  input  logic        idu_alu_halfop,
  input  logic [4:0]  idu_alu_opcode,
  input  logic        idu_jump_en,
  input  logic        idu_branch_en,
  input  logic [2:0]  idu_branch_opcode,
  input  logic        idu_load_en,
  input  logic        idu_store_en,
  input  logic        idu_wb_en,
  input  logic        idu_ebreak,
  input  logic [2:0]  idu_load_opcode,
  input  logic [3:0]  idu_store_len,
  input  logic [3:0]  idu_wb_choose,
  input  logic [31:0] idu_instr,
  input  logic [4:0]  mmu_index_rd,
  input  logic [63:0] mmu_wb_data,
  input  logic        mmu_wb_en,
  input  logic        mmu_jump_en,
  input  logic        mmu_branch_en,
  output logic        flush_nop,
  output logic [4:0]  exu_index_rd,
  output logic [4:0]  exu_index_rs1,
  output logic [4:0]  exu_index_rs2,
  output logic [63:0] exu_alu_result,
  output logic [63:0] exu_branch_pc,
  output logic [63:0] exu_gpr_data2,
  output logic [63:0] exu_imm,
  output logic [63:0] exu_snxt_pc,
  output logic        exu_jump_en,
  output logic        exu_branch_en,
  output logic        exu_branch_result,
  output logic        exu_load_en,
  output logic        exu_store_en,
  output logic        exu_wb_en,
  output logic        exu_ebreak,
  output logic [2:0]  exu_load_opcode,
  output logic [3:0]  exu_store_len,
  output logic [3:0]  exu_wb_choose,
  output logic [31:0] exu_instr
);

  typedef struct packed {
    logic [4:0]  index_rd, index_rs1, index_rs2;
    logic [63:0] alu_result, branch_pc, gpr_data2, imm, snxt_pc;
    logic        jump_en, branch_en, branch_result, load_en, store_en, wb_en, ebreak;
    logic [2:0]  load_opcode;
    logic [3:0]  store_len, wb_choose;
    logic [31:0] instr;
  } ex_t;

  localparam ex_t EX_BUBBLE = '{instr: 32'h0000_0013, default: '0};

  ex_t         ex_d, ex_q;
  logic [63:0] rs1_fwd, rs2_fwd, op_a, op_b, a_s, a_u, b_s, b_u, alu_raw, alu_out;
  logic [5:0]  shamt;
  logic        br_cond;
`ifdef EXU_MULDIV_EN
  logic [127:0] p_ss, p_su, p_uu;
  logic         div_ovf;
`endif

  // EX/MEM result has priority over MEM/WB; x0 always reads the register file
  always_comb begin
    rs1_fwd = idu_gpr_data1;
    rs2_fwd = idu_gpr_data2;
    if (idu_index_rs1 != 5'd0) begin
      if (ex_q.wb_en && ex_q.index_rd == idu_index_rs1) rs1_fwd = ex_q.alu_result;
      else if (mmu_wb_en && mmu_index_rd == idu_index_rs1) rs1_fwd = mmu_wb_data;
    end
    if (idu_index_rs2 != 5'd0) begin
      if (ex_q.wb_en && ex_q.index_rd == idu_index_rs2) rs2_fwd = ex_q.alu_result;
      else if (mmu_wb_en && mmu_index_rd == idu_index_rs2) rs2_fwd = mmu_wb_data;
    end
  end

  // W ops reuse the 64-bit datapath on extended operands; the result is re-extended from bit 31
  always_comb begin
    op_a  = idu_alu_pc_en ? idu_pc : rs1_fwd;
    op_b  = idu_alu_imm_en ? idu_imm : rs2_fwd;
    a_s   = idu_alu_halfop ? {{32{op_a[31]}}, op_a[31:0]} : op_a;
    a_u   = idu_alu_halfop ? {32'd0, op_a[31:0]} : op_a;
    b_s   = idu_alu_halfop ? {{32{op_b[31]}}, op_b[31:0]} : op_b;
    b_u   = idu_alu_halfop ? {32'd0, op_b[31:0]} : op_b;
    shamt = idu_alu_halfop ? {1'b0, op_b[4:0]} : op_b[5:0];
  end

`ifdef EXU_MULDIV_EN
  always_comb begin
    p_ss    = {{64{a_s[63]}}, a_s} * {{64{b_s[63]}}, b_s};
    p_su    = {{64{a_s[63]}}, a_s} * {64'd0, b_u};
    p_uu    = {64'd0, a_u} * {64'd0, b_u};
    div_ovf = (a_s == 64'h8000_0000_0000_0000) && (b_s == '1);
  end
`endif

  always_comb begin
    alu_raw = '0;
    case (idu_alu_opcode)
      5'd0:  alu_raw = a_s + b_s;
      5'd1:  alu_raw = a_s - b_s;
      5'd2:  alu_raw = a_s << shamt;
      5'd3:  alu_raw = {63'd0, $signed(a_s) < $signed(b_s)};
      5'd4:  alu_raw = {63'd0, a_u < b_u};
      5'd5:  alu_raw = a_s ^ b_s;
      5'd6:  alu_raw = a_u >> shamt;
      5'd7:  alu_raw = $signed(a_s) >>> shamt;
      5'd8:  alu_raw = a_s | b_s;
      5'd9:  alu_raw = a_s & b_s;
`ifdef EXU_MULDIV_EN
      5'd10: alu_raw = p_ss[63:0];
      5'd11: alu_raw = idu_alu_halfop ? {32'd0, p_ss[63:32]} : p_ss[127:64];
      5'd12: alu_raw = idu_alu_halfop ? {32'd0, p_su[63:32]} : p_su[127:64];
      5'd13: alu_raw = idu_alu_halfop ? {32'd0, p_uu[63:32]} : p_uu[127:64];
      5'd14: alu_raw = (b_s == 64'd0) ? '1 : div_ovf ? a_s : $signed(a_s) / $signed(b_s);
      5'd15: alu_raw = (b_u == 64'd0) ? '1 : a_u / b_u;
      5'd16: alu_raw = (b_s == 64'd0) ? a_s : div_ovf ? 64'd0 : $signed(a_s) % $signed(b_s);
      5'd17: alu_raw = (b_u == 64'd0) ? a_u : a_u % b_u;
`endif
      5'd18: alu_raw = b_s;
      default: alu_raw = '0;
    endcase
    if (!idu_alu_en)         alu_out = '0;
    else if (idu_alu_halfop) alu_out = {{32{alu_raw[31]}}, alu_raw[31:0]};
    else                     alu_out = alu_raw;
  end

  always_comb begin
    case (idu_branch_opcode)
      3'b000:  br_cond = rs1_fwd == rs2_fwd;
      3'b001:  br_cond = rs1_fwd != rs2_fwd;
      3'b100:  br_cond = $signed(rs1_fwd) < $signed(rs2_fwd);
      3'b101:  br_cond = $signed(rs1_fwd) >= $signed(rs2_fwd);
      3'b110:  br_cond = rs1_fwd < rs2_fwd;
      3'b111:  br_cond = rs1_fwd >= rs2_fwd;
      default: br_cond = 1'b0;
    endcase
  end

  assign flush_nop = mmu_jump_en | mmu_branch_en;

  always_comb begin
    ex_d               = EX_BUBBLE;
    if (!flush_nop) begin
      ex_d.index_rd      = idu_index_rd;
      ex_d.index_rs1     = idu_index_rs1;
      ex_d.index_rs2     = idu_index_rs2;
      ex_d.alu_result    = idu_jump_en ? idu_snxt_pc : alu_out;
      ex_d.branch_pc     = (idu_jump_en && !idu_alu_pc_en) ? ((rs1_fwd + idu_imm) & ~64'd1)
                                                           : (idu_pc + idu_imm);
      ex_d.gpr_data2     = rs2_fwd;
      ex_d.imm           = idu_imm;
      ex_d.snxt_pc       = idu_snxt_pc;
      ex_d.jump_en       = idu_jump_en;
      ex_d.branch_en     = idu_branch_en;
      ex_d.branch_result = idu_branch_en && br_cond;
      ex_d.load_en       = idu_load_en;
      ex_d.store_en      = idu_store_en;
      ex_d.wb_en         = idu_wb_en;
      ex_d.ebreak        = idu_ebreak;
      ex_d.load_opcode   = idu_load_opcode;
      ex_d.store_len     = idu_store_len;
      ex_d.wb_choose     = idu_wb_choose;
      ex_d.instr         = idu_instr;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) ex_q <= EX_BUBBLE;
    else      ex_q <= ex_d;
  end

  assign exu_index_rd      = ex_q.index_rd;
  assign exu_index_rs1     = ex_q.index_rs1;
  assign exu_index_rs2     = ex_q.index_rs2;
  assign exu_alu_result    = ex_q.alu_result;
  assign exu_branch_pc     = ex_q.branch_pc;
  assign exu_gpr_data2     = ex_q.gpr_data2;
  assign exu_imm           = ex_q.imm;
  assign exu_snxt_pc       = ex_q.snxt_pc;
  assign exu_jump_en       = ex_q.jump_en;
  assign exu_branch_en     = ex_q.branch_en;
  assign exu_branch_result = ex_q.branch_result;
  assign exu_load_en       = ex_q.load_en;
  assign exu_store_en      = ex_q.store_en;
  assign exu_wb_en         = ex_q.wb_en;
  assign exu_ebreak        = ex_q.ebreak;
  assign exu_load_opcode   = ex_q.load_opcode;
  assign exu_store_len     = ex_q.store_len;
  assign exu_wb_choose     = ex_q.wb_choose;
  assign exu_instr         = ex_q.instr;

endmodule

// File: tb/tb_exu_stage.sv
// tb/tb_exu_stage.sv - randomized and directed bench for exu_stage against a behavioural model.
module tb_exu_stage;
  logic clk = 1'b0, rstn;
  logic [4:0]  idu_index_rs1, idu_index_rs2, idu_index_rd, idu_alu_opcode, mmu_index_rd;
  logic [63:0] idu_pc, idu_snxt_pc, idu_imm, idu_gpr_data1, idu_gpr_data2, mmu_wb_data;
  logic        idu_alu_en, idu_alu_imm_en, idu_alu_pc_en, idu_alu_halfop, idu_jump_en, idu_branch_en;
  logic [2:0]  idu_branch_opcode, idu_load_opcode, exu_load_opcode;
  logic        idu_load_en, idu_store_en, idu_wb_en, idu_ebreak, mmu_wb_en, mmu_jump_en, mmu_branch_en;
  logic [3:0]  idu_store_len, idu_wb_choose, exu_store_len, exu_wb_choose;
  logic [31:0] idu_instr, exu_instr;
  logic        flush_nop, exu_jump_en, exu_branch_en, exu_branch_result, exu_load_en, exu_store_en;
  logic        exu_wb_en, exu_ebreak;
  logic [4:0]  exu_index_rd, exu_index_rs1, exu_index_rs2;
  logic [63:0] exu_alu_result, exu_branch_pc, exu_gpr_data2, exu_imm, exu_snxt_pc;

  exu_stage dut (
    .clk(clk), .rstn(rstn),
    .idu_index_rs1(idu_index_rs1), .idu_index_rs2(idu_index_rs2), .idu_index_rd(idu_index_rd),
    .idu_pc(idu_pc), .idu_snxt_pc(idu_snxt_pc), .idu_imm(idu_imm),
    .idu_gpr_data1(idu_gpr_data1), .idu_gpr_data2(idu_gpr_data2),
    .idu_alu_en(idu_alu_en), .idu_alu_imm_en(idu_alu_imm_en), .idu_alu_pc_en(idu_alu_pc_en),
    .idu_alu_halfop(idu_alu_halfop), .idu_alu_opcode(idu_alu_opcode),
    .idu_jump_en(idu_jump_en), .idu_branch_en(idu_branch_en), .idu_branch_opcode(idu_branch_opcode),
    .idu_load_en(idu_load_en), .idu_store_en(idu_store_en), .idu_wb_en(idu_wb_en), .idu_ebreak(idu_ebreak),
    .idu_load_opcode(idu_load_opcode), .idu_store_len(idu_store_len), .idu_wb_choose(idu_wb_choose),
    .idu_instr(idu_instr),
    .mmu_index_rd(mmu_index_rd), .mmu_wb_data(mmu_wb_data), .mmu_wb_en(mmu_wb_en),
    .mmu_jump_en(mmu_jump_en), .mmu_branch_en(mmu_branch_en),
    .flush_nop(flush_nop),
    .exu_index_rd(exu_index_rd), .exu_index_rs1(exu_index_rs1), .exu_index_rs2(exu_index_rs2),
    .exu_alu_result(exu_alu_result), .exu_branch_pc(exu_branch_pc), .exu_gpr_data2(exu_gpr_data2),
    .exu_imm(exu_imm), .exu_snxt_pc(exu_snxt_pc),
    .exu_jump_en(exu_jump_en), .exu_branch_en(exu_branch_en), .exu_branch_result(exu_branch_result),
    .exu_load_en(exu_load_en), .exu_store_en(exu_store_en), .exu_wb_en(exu_wb_en), .exu_ebreak(exu_ebreak),
    .exu_load_opcode(exu_load_opcode), .exu_store_len(exu_store_len), .exu_wb_choose(exu_wb_choose),
    .exu_instr(exu_instr)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  // model of what the EX/MEM register currently holds (for forwarding) and what it must hold next
  logic [4:0]  m_rd;
  logic        m_wb;
  logic [63:0] m_res;
  logic [63:0] x_res, x_bpc, x_gd2, x_imm;
  logic [4:0]  x_rd;
  logic        x_wb, x_st, x_jmp, x_br, x_bres, x_ld;
  logic [31:0] x_instr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                                          input logic half);
    logic [31:0] x, y, r;
    logic signed [63:0] sx, sy, sw;
    logic [63:0] ux, uy, uw, r64;
    logic signed [127:0] sa, sb, pw;
    logic [127:0] pu;
    x = a[31:0]; y = b[31:0];
    sx = {{32{x[31]}}, x}; sy = {{32{y[31]}}, y}; ux = {32'd0, x}; uy = {32'd0, y};
    sa = {{64{a[63]}}, a}; sb = {{64{b[63]}}, b};
    r = '0; r64 = '0;
    if (half) begin
      case (op)
        5'd0: r = x + y;
        5'd1: r = x - y;
        5'd2: r = x << y[4:0];
        5'd3: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        5'd4: r = (x < y) ? 32'd1 : 32'd0;
        5'd5: r = x ^ y;
        5'd6: r = x >> y[4:0];
        5'd7: r = $signed(x) >>> y[4:0];
        5'd8: r = x | y;
        5'd9: r = x & y;
`ifdef EXU_MULDIV_EN
        5'd10: r = x * y;
        5'd11: begin sw = sx * sy; r = sw[63:32]; end
        5'd12: begin sw = sx * $signed(ux); r = sw[63:32]; end
        5'd13: begin uw = ux * uy; r = uw[63:32]; end
        5'd14: r = (y == 0) ? '1 : (x == 32'h8000_0000 && y == '1) ? x : $signed(x) / $signed(y);
        5'd15: r = (y == 0) ? '1 : x / y;
        5'd16: r = (y == 0) ? x : (x == 32'h8000_0000 && y == '1) ? 32'd0 : $signed(x) % $signed(y);
        5'd17: r = (y == 0) ? x : x % y;
`endif
        5'd18: r = y;
        default: r = '0;
      endcase
      return {{32{r[31]}}, r};
    end
    case (op)
      5'd0: r64 = a + b;
      5'd1: r64 = a - b;
      5'd2: r64 = a << b[5:0];
      5'd3: r64 = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      5'd4: r64 = (a < b) ? 64'd1 : 64'd0;
      5'd5: r64 = a ^ b;
      5'd6: r64 = a >> b[5:0];
      5'd7: r64 = $signed(a) >>> b[5:0];
      5'd8: r64 = a | b;
      5'd9: r64 = a & b;
`ifdef EXU_MULDIV_EN
      5'd10: r64 = a * b;
      5'd11: begin pw = sa * sb; r64 = pw[127:64]; end
      5'd12: begin pw = sa * $signed({64'd0, b}); r64 = pw[127:64]; end
      5'd13: begin pu = {64'd0, a} * {64'd0, b}; r64 = pu[127:64]; end
      5'd14: r64 = (b == 0) ? '1 : (a == {1'b1, 63'd0} && b == '1) ? a : $signed(a) / $signed(b);
      5'd15: r64 = (b == 0) ? '1 : a / b;
      5'd16: r64 = (b == 0) ? a : (a == {1'b1, 63'd0} && b == '1) ? 64'd0 : $signed(a) % $signed(b);
      5'd17: r64 = (b == 0) ? a : a % b;
`endif
      5'd18: r64 = b;
      default: r64 = '0;
    endcase
    return r64;
  endfunction

  function automatic logic [63:0] fwd(input logic [4:0] idx, input logic [63:0] rf);
    if (idx == 0) return rf;
    if (m_wb && m_rd == idx) return m_res;
    if (mmu_wb_en && mmu_index_rd == idx) return mmu_wb_data;
    return rf;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 8))
      0: return 64'd0;
      1: return '1;
      2: return 64'd1;
      3: return {1'b1, 63'd0};
      4: return 64'h0000_0000_7FFF_FFFF;
      5: return 64'hFFFF_FFFF_8000_0000;
      6: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic clr();
    {idu_index_rs1, idu_index_rs2, idu_index_rd, idu_alu_opcode, mmu_index_rd} = '0;
    {idu_pc, idu_snxt_pc, idu_imm, idu_gpr_data1, idu_gpr_data2, mmu_wb_data} = '0;
    {idu_alu_en, idu_alu_imm_en, idu_alu_pc_en, idu_alu_halfop, idu_jump_en, idu_branch_en} = '0;
    {idu_branch_opcode, idu_load_opcode, idu_store_len, idu_wb_choose, idu_instr} = '0;
    {idu_load_en, idu_store_en, idu_wb_en, idu_ebreak, mmu_wb_en, mmu_jump_en, mmu_branch_en} = '0;
  endtask

  task automatic randomize_inputs();
    idu_index_rs1 = 5'($urandom_range(0, 7));
    idu_index_rs2 = 5'($urandom_range(0, 7));
    idu_index_rd  = 5'($urandom_range(0, 7));
    idu_pc = rnd64(); idu_snxt_pc = rnd64(); idu_imm = rnd64();
    idu_gpr_data1 = rnd64(); idu_gpr_data2 = rnd64(); mmu_wb_data = rnd64();
    idu_alu_en = ($urandom_range(0, 9) != 0);
    idu_alu_imm_en = $urandom_range(0, 1) == 1;
    idu_alu_pc_en  = $urandom_range(0, 4) == 0;
    idu_alu_halfop = $urandom_range(0, 2) == 0;
    idu_alu_opcode = ($urandom_range(0, 9) != 0) ? 5'($urandom_range(0, 18)) : 5'($urandom_range(19, 31));
    idu_jump_en   = $urandom_range(0, 9) == 0;
    idu_branch_en = $urandom_range(0, 3) == 0;
    idu_branch_opcode = 3'($urandom_range(0, 7));
    idu_load_en = $urandom_range(0, 3) == 0; idu_store_en = $urandom_range(0, 3) == 0;
    idu_wb_en = $urandom_range(0, 1) == 1;   idu_ebreak = $urandom_range(0, 15) == 0;
    idu_load_opcode = 3'($urandom); idu_store_len = 4'($urandom); idu_wb_choose = 4'($urandom);
    idu_instr = $urandom;
    mmu_index_rd = 5'($urandom_range(0, 7)); mmu_wb_en = $urandom_range(0, 1) == 1;
    mmu_jump_en = $urandom_range(0, 19) == 0; mmu_branch_en = $urandom_range(0, 14) == 0;
  endtask

  // one clock: predict from current inputs, clock, compare EX/MEM contents
  task automatic step();
    logic [63:0] f1, f2, a, b;
    logic cond, flush;
    #1;
    f1 = fwd(idu_index_rs1, idu_gpr_data1);
    f2 = fwd(idu_index_rs2, idu_gpr_data2);
    a = idu_alu_pc_en ? idu_pc : f1;
    b = idu_alu_imm_en ? idu_imm : f2;
    case (idu_branch_opcode)
      3'b000: cond = (f1 == f2);
      3'b001: cond = (f1 != f2);
      3'b100: cond = ($signed(f1) < $signed(f2));
      3'b101: cond = !($signed(f1) < $signed(f2));
      3'b110: cond = (f1 < f2);
      3'b111: cond = !(f1 < f2);
      default: cond = 1'b0;
    endcase
    flush = mmu_jump_en || mmu_branch_en;
    chk("flush_nop", 64'(flush_nop), 64'(flush));
    if (flush) begin
      {x_res, x_bpc, x_gd2, x_imm} = '0;
      {x_rd, x_wb, x_st, x_jmp, x_br, x_bres, x_ld} = '0;
      x_instr = 32'h0000_0013;
    end else begin
      x_res = idu_jump_en ? idu_snxt_pc : (idu_alu_en ? ref_alu(idu_alu_opcode, a, b, idu_alu_halfop) : 64'd0);
      x_bpc = (idu_jump_en && !idu_alu_pc_en) ? {f1[63:1] + idu_imm[63:1] + 63'(f1[0] & idu_imm[0]), 1'b0}
                                              : idu_pc + idu_imm;
      x_gd2 = f2; x_imm = idu_imm; x_rd = idu_index_rd; x_wb = idu_wb_en; x_st = idu_store_en;
      x_jmp = idu_jump_en; x_br = idu_branch_en; x_bres = idu_branch_en && cond; x_ld = idu_load_en;
      x_instr = idu_instr;
    end
    @(posedge clk); #1;
    chk("alu_result", exu_alu_result, x_res);
    if (x_jmp || x_br) chk("branch_pc", exu_branch_pc, x_bpc);
    chk("branch_result", 64'(exu_branch_result), 64'(x_bres));
    chk("gpr_data2", exu_gpr_data2, x_gd2);
    chk("imm", exu_imm, x_imm);
    chk("index_rd", 64'(exu_index_rd), 64'(x_rd));
    chk("wb_en", 64'(exu_wb_en), 64'(x_wb));
    chk("store_en", 64'(exu_store_en), 64'(x_st));
    chk("load_en", 64'(exu_load_en), 64'(x_ld));
    chk("jump_en", 64'(exu_jump_en), 64'(x_jmp));
    chk("instr", 64'(exu_instr), 64'(x_instr));
    m_rd = x_rd; m_wb = x_wb; m_res = x_res;
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] imm, input logic half);
    clr();
    idu_alu_en = 1'b1; idu_alu_imm_en = 1'b1; idu_alu_opcode = op; idu_alu_halfop = half;
    idu_index_rs1 = 5'd3; idu_gpr_data1 = a; idu_imm = imm;
  endtask

  task automatic check_bubble(input string tag);
    chk({tag, "_instr"}, 64'(exu_instr), 64'h13);
    chk({tag, "_wb"}, 64'(exu_wb_en), 64'd0);
    chk({tag, "_store"}, 64'(exu_store_en), 64'd0);
    chk({tag, "_res"}, exu_alu_result, 64'd0);
    chk({tag, "_rd"}, 64'(exu_index_rd), 64'd0);
  endtask

  initial begin
    clr();
    rstn = 1'b1;
    #3 check_bubble("rst_async");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    m_rd = '0; m_wb = 1'b0; m_res = '0;
    check_bubble("rst_hold");

    alu_op(5'd0, 64'd5, -64'sd7, 1'b0); step();
    chk("add_neg", exu_alu_result, 64'hFFFF_FFFF_FFFF_FFFE);
    alu_op(5'd0, 64'h7FFF_FFFF, 64'd1, 1'b1); step();
    chk("addw_ovf", exu_alu_result, 64'hFFFF_FFFF_8000_0000);

    // EX beats MEM, x0 bypasses, MEM alone forwards
    alu_op(5'd0, 64'h11, 64'd0, 1'b0); idu_index_rs1 = 5'd0; idu_index_rd = 5'd5; idu_wb_en = 1'b1; step();
    alu_op(5'd0, 64'h33, 64'd0, 1'b0); idu_index_rs1 = 5'd5; idu_index_rd = 5'd5; idu_wb_en = 1'b1;
    mmu_index_rd = 5'd5; mmu_wb_data = 64'h22; mmu_wb_en = 1'b1; step();
    chk("fwd_ex_prio", exu_alu_result, 64'h11);
    alu_op(5'd0, 64'h33, 64'd0, 1'b0); idu_index_rs1 = 5'd0;
    mmu_index_rd = 5'd5; mmu_wb_data = 64'h22; mmu_wb_en = 1'b1; step();
    chk("fwd_x0", exu_alu_result, 64'h33);
    alu_op(5'd0, 64'h33, 64'd0, 1'b0); idu_index_rs1 = 5'd5;
    mmu_index_rd = 5'd5; mmu_wb_data = 64'h22; mmu_wb_en = 1'b1; step();
    chk("fwd_mem", exu_alu_result, 64'h22);

    for (int k = 0; k < 2; k++) begin
      clr(); idu_branch_en = 1'b1; idu_branch_opcode = (k == 0) ? 3'b100 : 3'b110;
      idu_index_rs1 = 5'd1; idu_gpr_data1 = '1; idu_index_rs2 = 5'd2; idu_gpr_data2 = 64'd1;
      idu_pc = 64'h8000_0000; idu_imm = 64'd16; step();
      chk(k == 0 ? "blt" : "bltu", 64'(exu_branch_result), (k == 0) ? 64'd1 : 64'd0);
      chk("br_target", exu_branch_pc, 64'h8000_0010);
    end

    alu_op(5'd0, 64'h8000_0101, 64'd2, 1'b0); idu_index_rs1 = 5'd1; idu_jump_en = 1'b1;
    idu_snxt_pc = 64'h8000_0008; step();
    chk("jalr_pc", exu_branch_pc, 64'h8000_0102);
    chk("jalr_link", exu_alu_result, 64'h8000_0008);

    clr(); idu_store_en = 1'b1; idu_wb_en = 1'b1; idu_index_rd = 5'd4; idu_instr = 32'h00A1_3023;
    mmu_branch_en = 1'b1; #1 chk("flush_now", 64'(flush_nop), 64'd1);
    step(); check_bubble("flush");

    alu_op(5'd14, 64'd123, 64'd0, 1'b0); step();
`ifdef EXU_MULDIV_EN
    chk("div_zero", exu_alu_result, '1);
`else
    chk("div_zero", exu_alu_result, 64'd0);
`endif

    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      step();
    end

    randomize_inputs(); mmu_jump_en = 1'b0; mmu_branch_en = 1'b0; idu_wb_en = 1'b1; idu_instr = 32'h1234_5678;
    step();
    #2 rstn = 1'b1;
    #1 check_bubble("rst_mid");
    #1 rstn = 1'b0;
    #1 check_bubble("rst_release");
    m_rd = '0; m_wb = 1'b0; m_res = '0;
    for (int i = 0; i < 50; i++) begin
      randomize_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
